uart_send: RTL
==============

Name: uart_send

Overview:
- 8N1 UART transmitter: the transmit-side counterpart of the team's UART receive path.
- Accepts one byte per start pulse and serialises it on uart_tx: start bit (0), 8 data bits LSB first, stop bit (1).
- Shares the receiver's Baud_set encoding, so a paired link is configured identically.
- Sits between the byte-producing logic and the board TX pin; uses a 50 MHz sysclk.

Parameters:
- CLK_FREQ, 50_000_000, sysclk frequency in Hz; used to derive the bit-period divisors.
- DIV_4800, CLK_FREQ/4800 (=10416), cycles per bit for Baud_set=0.
- DIV_9600, CLK_FREQ/9600 (=5208), cycles per bit for Baud_set=1.
- DIV_115200, CLK_FREQ/115200 (=434), cycles per bit for Baud_set=2 and all other codes.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the sysclk rising edge.
- Baud_set  in  3  0=4800, 1=9600, 2=115200, 3..7=115200.
- Data  in  8  byte to send; sampled only when a send is accepted.
- send_go  in  1  start request; effective only while idle.
- uart_tx  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is in progress.
- tx_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst=0 at an edge): uart_tx=1, tx_busy=0, tx_done=0; the bit counter, divider counter and shift register clear. A reset mid-frame aborts the frame: the line is high from the next cycle, and tx_done does not pulse.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START: on an edge with send_go=1 and tx_busy=0.
  - Data latches into an 8-bit shift register.
  - Baud_set decodes to a divisor, latched as a 14-bit DIV_L.
  - uart_tx=0 and tx_busy=1 from the next cycle onward.
- Divider: a 14-bit counter runs 0..DIV_L-1 in every non-IDLE state. Each bit is exactly DIV_L cycles long. Wrap to 0 marks the bit boundary.
- START -> DATA at the boundary: uart_tx=Data[0].
- DATA: at each boundary, shift right and output the next bit. A 3-bit index counts 0..7. After bit 7's period ends, move to STOP with uart_tx=1.
- STOP: lasts DIV_L cycles. At its boundary, return to IDLE: tx_busy=0 and tx_done=1 for exactly one cycle, with uart_tx held at 1.
- Total frame: 10*DIV_L cycles from the first start-bit cycle to the first cycle with tx_busy=0.
- Back-to-back: send_go sampled in the tx_done cycle is accepted (tx_busy is already 0). This gives a zero-idle-gap next frame, i.e. a start bit directly after the stop bit.
- send_go while tx_busy=1: ignored entirely, with no queuing. Data and Baud_set changes mid-frame have no effect, since both were latched at accept.
- send_go held high continuously: one frame per acceptance window, so frames repeat back-to-back.
- uart_tx is driven directly from a register, so the line is glitch-free.
- Counter widths: the max DIV_L-1 of 10415 fits in 14 bits. There is no overflow path.

Decomposition:
- Shared package uart_pkg holds:
  - the CLK_FREQ default;
  - the DIV_4800, DIV_9600 and DIV_115200 constants;
  - the Baud_set code constants (BAUD_4800=0, BAUD_9600=1, BAUD_115200=2);
  - the FSM state enum and FRAME_BITS=10.
- The receiver migrates to the same constants.
- One natural sub-module: baud_div_gen, a 14-bit bit-period counter with enable, load-divisor and a tick output. It is reusable by the receiver's oversampling path.

Test Plan:
- Baud_set=2, Data=0x55, send_go 1 cycle:
  - uart_tx is 0,1,0,1,0,1,0,1,0,1, each level exactly 434 cycles.
  - tx_done pulses once, 4340 cycles after the start-bit first cycle.
  - tx_busy is high for exactly 4340 cycles.
- Baud_set=1, Data=0xA3: bits sent are 0,1,1,0,0,0,1,0,1 then stop 1, each 5208 cycles. Repeat with Baud_set=0: each bit 10416 cycles.
- Baud_set=7, Data=0x00: 434-cycle bits (default divisor); the line is low for 9*434 cycles, then high.
- Mid-frame disturbance during DATA with Baud_set=2:
  - Pulse send_go with Data=0xFF and change Baud_set to 0.
  - The frame continues unchanged at 434 cycles/bit with the original byte. No second frame starts.
- send_go held high with Data=0x0F: two consecutive frames with zero idle gap; tx_done pulses every 4340 cycles.
- Assert rst=0 for 1 cycle in the middle of bit 4:
  - The next cycle shows uart_tx=1, tx_busy=0, with no tx_done.
  - A subsequent send_go with Data=0x81 transmits a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: clock default, bit-period divisors, Baud_set codes and TX FSM encoding.
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned DIV_4800   = CLK_FREQ / 4800;
  localparam int unsigned DIV_9600   = CLK_FREQ / 9600;
  localparam int unsigned DIV_115200 = CLK_FREQ / 115200;

  // Largest divisor minus one is 10415, so 14 bits covers every bit period.
  localparam int unsigned DIV_W = 14;

  localparam logic [2:0] BAUD_4800   = 3'd0;
  localparam logic [2:0] BAUD_9600   = 3'd1;
  localparam logic [2:0] BAUD_115200 = 3'd2;

  localparam int unsigned FRAME_BITS = 10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_send_baud_div_gen.sv
// Bit-period counter: runs 0..div-1 while enabled and flags the last cycle of each period.
module baud_div_gen
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == (div_q - 1'b1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || !en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) begin
        div_q <= div_i;
      end
    end
  end

endmodule

// File: rtl/uart_send.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit; one byte per accepted send_go.
// Byte and divisor are latched at accept, so mid-frame input changes are ignored.
module uart_send #(
  parameter int unsigned CLK_FREQ   = uart_pkg::CLK_FREQ,
  parameter int unsigned DIV_4800   = CLK_FREQ / 4800,
  parameter int unsigned DIV_9600   = CLK_FREQ / 9600,
  parameter int unsigned DIV_115200 = CLK_FREQ / 115200
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [2:0] Baud_set,
  input  logic [7:0] Data,
  input  logic       send_go,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  import uart_pkg::*;

  state_t           state_q, state_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] div_sel;
  logic             accept;
  logic             tick;

  always_comb begin
    case (Baud_set)
      BAUD_4800: div_sel = DIV_W'(DIV_4800);
      BAUD_9600: div_sel = DIV_W'(DIV_9600);
      default:   div_sel = DIV_W'(DIV_115200);
    endcase
  end

  assign accept = (state_q == ST_IDLE) && send_go && !busy_q;

  baud_div_gen u_baud_div_gen (
    .clk_i  (sysclk),
    .rst_ni (rst),
    .en_i   (state_q != ST_IDLE),
    .load_i (accept),
    .div_i  (div_sel),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          sh_d    = Data;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = sh_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign uart_tx = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
